muldiv_issue: RTL and testbench
===============================

MULDIV_ISSUE -- requirements
Module: muldiv_issue

Interface
REQ-001 SHALL use clock clk and reset reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 ex_valid  in  1  EX stage holds a valid instruction.
REQ-005 ex_opcode  in  7, ex_funct7  in  7, ex_funct3  in  3  decoded instruction fields.
REQ-006 ex_rs1, ex_rs2  in  32  source operand values; ex_rd  in  5  destination register.
REQ-007 flush  in  1  kill the instruction currently in EX.
REQ-008 md_start  out  1  one-cycle start pulse to the mul/div unit.
REQ-009 md_A, md_B  out  32  operands to the unit.
REQ-010 md_op_mul, md_op_div  out  2  operation selects; md_sel  out  1  0 = multiply, 1 = divide.
REQ-011 md_R  in  32  unit result; md_done  in  1  unit completion.
REQ-012 stall  out  1  hold the pipeline; wb_valid  out  1  result valid; wb_rd  out  5; wb_data  out  32.

Function
REQ-013 An M-op is ex_opcode=0110011 with ex_funct7=0000001; all other instructions SHALL produce no start and no stall.
REQ-014 Decode SHALL be md_sel=funct3[2], md_op_mul=funct3[1:0] when md_sel=0 (else 00), and md_op_div=funct3[1:0] when md_sel=1 (else 00), with op_div[1]=remainder and op_div[0]=unsigned.
REQ-015 The FSM SHALL have states IDLE, START, BUSY, DONE and DRAIN.
REQ-016 IDLE: when ex_valid & M-op & !flush, latch rs1, rs2, rd and the decoded op; go to START; stall=1 combinationally in that cycle.
REQ-017 START: md_start=1 for exactly this cycle; go to BUSY, or to DRAIN if flush=1.
REQ-018 BUSY: stall=1; on md_done go to DONE and capture md_R and the latched rd; on flush without md_done go to DRAIN; flush together with md_done goes to IDLE with no writeback.
REQ-019 DONE: wb_valid = !flush and stall=0 for one cycle; then go to IDLE; DONE SHALL NOT accept a new op.
REQ-020 DRAIN: stall = ex_valid & M-op; stay until md_done, then go to IDLE; no wb_valid; md_R is discarded.
REQ-021 md_A, md_B and the op selects SHALL hold constant from START until the cycle after md_done, because the unit samples operand sign bits in its output stage.
REQ-022 md_done in IDLE or DONE SHALL be ignored.
REQ-023 Minimum latency SHALL be: accept cycle, then START, then md_done at the earliest in the cycle after START, then DONE.
REQ-024 wb_data and wb_rd SHALL hold their last value outside DONE.

Reset
REQ-025 On reset: state=IDLE; md_start, stall, wb_valid, md_sel, md_op_mul, md_op_div all 0; md_A, md_B, wb_data all 0; wb_rd=0.
REQ-026 Reset mid-operation SHALL abandon the op; a later md_done SHALL be ignored.

Structure
REQ-027 Package muldiv_pkg SHALL hold the FSM state encoding, OPCODE_OP=0110011, FUNCT7_MULDIV=0000001 and the eight funct3 codes (MUL through REMU).
REQ-028 Combinational decode SHALL live in a sub-module muldiv_decode; the FSM and registers SHALL live in muldiv_issue.

Verification
REQ-029 MUL, rs1=7, rs2=6, rd=5; model md_done 3 cycles after md_start with md_R=42 -> single md_start with md_sel=0 and md_op_mul=00; wb_valid for 1 cycle with wb_data=42 and wb_rd=5; stall high from accept until DONE.
REQ-030 DIVU (funct3=101), rs1=100, rs2=7; md_R=14 -> md_sel=1, md_op_div=01, wb_data=14.
REQ-031 flush during BUSY, then a new MUL presented -> stall stays high only while the new op waits; no wb_valid for the killed op; new md_start only after the old md_done.
REQ-032 ADD (funct7=0000000) with ex_valid=1 -> md_start=0, stall=0.
REQ-033 reset asserted in BUSY, md_done pulsed after release -> all outputs 0 and no wb_valid.
REQ-034 MULHU then REM back-to-back -> second md_start only after the first DONE; md_A unchanged until the first md_done + 1.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension issue stage: FSM states,
// instruction encodings and the decoded operation bundle.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_DONE,
    ST_DRAIN
  } md_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // op_div[1] = remainder, op_div[0] = unsigned
  typedef struct packed {
    logic       sel;
    logic [1:0] op_mul;
    logic [1:0] op_div;
  } md_op_t;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational recognition and decode of RV32M instructions into
// unit select / operation fields.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic       is_mop_o,
  output md_op_t     op_o
);

  always_comb begin
    is_mop_o  = (opcode_i == OPCODE_OP) && (funct7_i == FUNCT7_MULDIV);
    op_o.sel    = funct3_i[2];
    op_o.op_mul = funct3_i[2] ? 2'b00 : funct3_i[1:0];
    op_o.op_div = funct3_i[2] ? funct3_i[1:0] : 2'b00;
  end

endmodule

// File: rtl/muldiv_issue.sv
// Issue/writeback control for a multi-cycle mul/div unit: latches the
// EX-stage M-op, starts the unit, stalls the pipe and drains killed ops.
module muldiv_issue
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [6:0]  ex_funct7,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        md_start,
  output logic [31:0] md_A,
  output logic [31:0] md_B,
  output logic [1:0]  md_op_mul,
  output logic [1:0]  md_op_div,
  output logic        md_sel,
  input  logic [31:0] md_R,
  input  logic        md_done,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  md_state_e   state_q, state_d;
  logic [31:0] a_q, b_q;
  md_op_t      op_q;
  logic [4:0]  rd_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic   is_mop;
  md_op_t dec_op;
  logic   accept;
  logic   latch;
  logic   capture;

  muldiv_decode u_decode (
    .opcode_i (ex_opcode),
    .funct7_i (ex_funct7),
    .funct3_i (ex_funct3),
    .is_mop_o (is_mop),
    .op_o     (dec_op)
  );

  assign accept = ex_valid & is_mop & ~flush;

  always_comb begin
    state_d  = state_q;
    md_start = 1'b0;
    stall    = 1'b0;
    wb_valid = 1'b0;
    latch    = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          latch   = 1'b1;
          stall   = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        md_start = 1'b1;
        stall    = 1'b1;
        state_d  = flush ? ST_DRAIN : ST_BUSY;
      end
      ST_BUSY: begin
        stall = 1'b1;
        // A flush coinciding with completion retires the unit without writeback
        if (md_done) begin
          capture = ~flush;
          state_d = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        wb_valid = ~flush;
        state_d  = ST_IDLE;
      end
      ST_DRAIN: begin
        stall = ex_valid & is_mop;
        if (md_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        a_q  <= ex_rs1;
        b_q  <= ex_rs2;
        op_q <= dec_op;
        rd_q <= ex_rd;
      end
      if (capture) begin
        wb_data_q <= md_R;
        wb_rd_q   <= rd_q;
      end
    end
  end

  assign md_A      = a_q;
  assign md_B      = b_q;
  assign md_sel    = op_q.sel;
  assign md_op_mul = op_q.op_mul;
  assign md_op_div = op_q.op_div;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Scoreboard bench for muldiv_issue: a modelled mul/div unit answers
// md_start, a driver plays the EX stage, a monitor checks writebacks.
module tb_muldiv_issue;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, flush;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2;
  logic [4:0]  ex_rd;
  logic        md_start, md_sel, md_done;
  logic [31:0] md_A, md_B, md_R;
  logic [1:0]  md_op_mul, md_op_div;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  muldiv_issue dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_opcode (ex_opcode),
    .ex_funct7 (ex_funct7),
    .ex_funct3 (ex_funct3),
    .ex_rs1    (ex_rs1),
    .ex_rs2    (ex_rs2),
    .ex_rd     (ex_rd),
    .flush     (flush),
    .md_start  (md_start),
    .md_A      (md_A),
    .md_B      (md_B),
    .md_op_mul (md_op_mul),
    .md_op_div (md_op_div),
    .md_sel    (md_sel),
    .md_R      (md_R),
    .md_done   (md_done),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   start_cnt = 0;
  int   wb_cnt = 0;
  int   fixed_lat = 0;
  bit   spur_en = 1'b0;
  logic       last_sel;
  logic [1:0] last_mul, last_div;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RV32M arithmetic, straight from the ISA definition
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      F3_MUL:    begin p = {32'b0, a} * {32'b0, b};                 return p[31:0];  end
      F3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};     return p[63:32]; end
      F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};           return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b};                 return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return 32'(sa / sb);
      end
      F3_DIVU: return (b == 0) ? '1 : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return '0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Mul/div unit model: latency counted from the md_start cycle
  initial begin : unit_model
    logic [31:0] ca, cb;
    logic        csel;
    logic [1:0]  cmul, cdiv;
    int          cnt;
    bit          busy, after, chk_ok;
    busy = 0; after = 0; chk_ok = 0; cnt = 0;
    ca = '0; cb = '0; csel = 0; cmul = '0; cdiv = '0;
    md_done = 1'b0;
    md_R = '0;
    forever begin
      @(negedge clk);
      md_done = 1'b0;
      md_R = $urandom;
      if (!reset) chk_ok = 0;
      if (after && chk_ok)
        chk("hold_after_done", {md_A, md_B, md_sel, md_op_mul, md_op_div}, {ca, cb, csel, cmul, cdiv});
      after = 0;
      if (md_start) begin
        chk("start_while_busy", busy, 1'b0);
      end
      if (busy) begin
        if (chk_ok)
          chk("hold_busy", {md_A, md_B, md_sel, md_op_mul, md_op_div}, {ca, cb, csel, cmul, cdiv});
        cnt--;
        if (cnt == 0) begin
          md_done = 1'b1;
          md_R = ref_md({csel, csel ? cdiv : cmul}, ca, cb);
          busy = 0;
          after = 1;
        end
      end else if (md_start) begin
        start_cnt++;
        ca = md_A; cb = md_B; csel = md_sel; cmul = md_op_mul; cdiv = md_op_div;
        last_sel = csel; last_mul = cmul; last_div = cdiv;
        chk("unused_select", csel ? cmul : cdiv, 2'b00);
        busy = 1; chk_ok = 1;
        cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(5, 1));
      end else if (spur_en && $urandom_range(7) == 0) begin
        md_done = 1'b1;
      end
    end
  end

  initial begin : monitor
    wb_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset && wb_valid) begin
        wb_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wb_unexpected: got rd=%0d data=%0h, expected no writeback", wb_rd, wb_data);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Holds an instruction in EX until the pipe advances (stall low) or it is flushed.
  // flush_at: >=0 flush on that cycle, -1 never, -2 random.
  task automatic issue(input logic [6:0] opc, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int flush_at, output int cycles);
    bit fin = 0;
    bit mop = (opc == OPCODE_OP) && (f7 == FUNCT7_MULDIV);
    cycles = 0;
    while (!fin && cycles < 100) begin
      @(negedge clk);
      ex_valid = 1'b1; ex_opcode = opc; ex_funct7 = f7; ex_funct3 = f3;
      ex_rs1 = a; ex_rs2 = b; ex_rd = rd;
      flush = (flush_at >= 0) ? (cycles == flush_at) : (flush_at == -2 && $urandom_range(9) == 0);
      #3;
      if (flush) fin = 1;
      else if (!stall) begin
        fin = 1;
        if (mop) exp_q.push_back('{rd, ref_md(f3, a, b)});
      end
      cycles++;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: stall still %0b after %0d cycles, expected release", stall, cycles);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      ex_valid = 1'b0; ex_opcode = OPCODE_OP; ex_funct7 = FUNCT7_MULDIV;
      ex_funct3 = 3'($urandom); ex_rs1 = $urandom; ex_rs2 = $urandom; ex_rd = 5'($urandom);
      flush = ($urandom_range(3) == 0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(9));
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc, s0, w0;
    logic [6:0] opc, f7;
    reset = 1'b0; ex_valid = 1'b0; flush = 1'b0;
    ex_opcode = '0; ex_funct7 = '0; ex_funct3 = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;

    repeat (2) begin
      @(negedge clk); #4;
      chk("reset_outputs", {md_start, stall, wb_valid, md_sel, md_op_mul, md_op_div, md_A, md_B, wb_data, wb_rd}, '0);
    end
    @(negedge clk); #2 reset = 1'b1;

    fixed_lat = 3; s0 = start_cnt; w0 = wb_cnt;
    issue(OPCODE_OP, FUNCT7_MULDIV, F3_MUL, 32'd7, 32'd6, 5'd5, -1, cyc);
    chk("mul_residency", cyc, 6);
    gap(2);
    chk("mul_starts", start_cnt - s0, 1);
    chk("mul_wbs", wb_cnt - w0, 1);
    chk("mul_select", {last_sel, last_mul}, 3'b0_00);

    fixed_lat = 2;
    issue(OPCODE_OP, FUNCT7_MULDIV, F3_DIVU, 32'd100, 32'd7, 5'd12, -1, cyc);
    chk("divu_select", {last_sel, last_div, last_mul}, 5'b1_01_00);
    gap(1);

    s0 = start_cnt;
    issue(OPCODE_OP, 7'b0000000, F3_MUL, 32'd3, 32'd4, 5'd1, -1, cyc);
    chk("add_residency", cyc, 1);
    gap(2);
    chk("add_starts", start_cnt - s0, 0);

    fixed_lat = 5; s0 = start_cnt; w0 = wb_cnt;
    issue(OPCODE_OP, FUNCT7_MULDIV, F3_MUL, 32'd9, 32'd9, 5'd2, 3, cyc);
    issue(OPCODE_OP, FUNCT7_MULDIV, F3_MUL, 32'd3, 32'd4, 5'd9, -1, cyc);
    chk("drain_wait_residency", cyc, 11);
    gap(2);
    chk("flush_starts", start_cnt - s0, 2);
    chk("flush_wbs", wb_cnt - w0, 1);

    fixed_lat = 0; s0 = start_cnt; w0 = wb_cnt;
    issue(OPCODE_OP, FUNCT7_MULDIV, F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd3, -1, cyc);
    issue(OPCODE_OP, FUNCT7_MULDIV, F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, -1, cyc);
    gap(2);
    chk("b2b_starts", start_cnt - s0, 2);
    chk("b2b_wbs", wb_cnt - w0, 2);

    fixed_lat = 4; s0 = start_cnt; w0 = wb_cnt;
    repeat (3) begin
      @(negedge clk);
      ex_valid = 1'b1; ex_opcode = OPCODE_OP; ex_funct7 = FUNCT7_MULDIV; ex_funct3 = F3_MUL;
      ex_rs1 = 32'd3; ex_rs2 = 32'd5; ex_rd = 5'd7; flush = 1'b0;
    end
    @(negedge clk); #1 reset = 1'b0; ex_valid = 1'b0;
    @(negedge clk); #2 reset = 1'b1;
    #2 chk("post_reset_outputs", {md_start, stall, wb_valid, md_sel, md_op_mul, md_op_div, md_A, md_B, wb_data, wb_rd}, '0);
    repeat (4) begin
      @(negedge clk); #4;
      chk("post_reset_outputs", {md_start, stall, wb_valid, md_sel, md_op_mul, md_op_div, md_A, md_B, wb_data, wb_rd}, '0);
    end
    chk("reset_starts", start_cnt - s0, 1);
    chk("reset_wbs", wb_cnt - w0, 0);

    fixed_lat = 0; spur_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(9))
        7:       begin opc = OPCODE_OP; f7 = ($urandom_range(1) == 0) ? 7'b0000000 : 7'b0100000; end
        8:       begin opc = 7'b0010011; f7 = FUNCT7_MULDIV; end
        9:       begin opc = OPCODE_OP; f7 = 7'b0000011; end
        default: begin opc = OPCODE_OP; f7 = FUNCT7_MULDIV; end
      endcase
      issue(opc, f7, 3'($urandom), pick(), pick(), 5'($urandom), -2, cyc);
      if ($urandom_range(2) == 0) gap(int'($urandom_range(2, 1)));
    end
    gap(12);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
